// File: rtl/mem_sched_pkg.sv
// Shared types for the data-memory port scheduler: FSM states,
// requester port ids and transaction kinds.
package mem_sched_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    PORT_NONE  = 2'd0,
    PORT_FETCH = 2'd1,
    PORT_DATA  = 2'd2,
    PORT_STACK = 2'd3
  } port_id_t;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_t;

  // One-hot completion vector for a port id: bit 0 = fetch, bit 1 = data, bit 2 = stack.
  function automatic logic [2:0] port_onehot(input port_id_t p);
    logic [2:0] v;
    v = 3'b000;
    case (p)
      PORT_FETCH: v = 3'b001;
      PORT_DATA:  v = 3'b010;
      PORT_STACK: v = 3'b100;
      default:    v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_sched_prio.sv
// Fixed-priority encoder: stack port beats data port beats fetch port.
module mem_sched_prio
  import mem_sched_pkg::*;
(
  input  logic     req1,
  input  logic     req2,
  input  logic     req3,
  output port_id_t grant
);

  // Pick the highest-priority eligible requester, or none.
  always_comb begin
    grant = PORT_NONE;
    if (req3) begin
      grant = PORT_STACK;
    end else if (req2) begin
      grant = PORT_DATA;
    end else if (req1) begin
      grant = PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_sched.sv
// Shares one single-ported, variable-latency data memory between the fetch,
// data-stage and stack requesters, one transaction at a time.
// Optional feature macro: MEMSCHED_TIMEOUT_EN (abort an access that waits
// TIMEOUT cycles for mem_ready and report it on err).
module mem_port_sched
  import mem_sched_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          read1,
  input  logic [AW-1:0] addr1,
  input  logic          read2,
  input  logic          write2,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] value2,
  input  logic          read3,
  input  logic [AW-1:0] addr3,
  output logic          blocked1,
  output logic          blocked2,
  output logic          blocked3,
  output logic          done1,
  output logic          done2,
  output logic          done3,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  state_t     state;
  port_id_t   port_q;
  kind_t      kind_q;
  port_id_t   grant;
  logic [2:0] done_q;
  logic       req1;
  logic       req2;
  logic       req3;

`ifdef MEMSCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
`endif

  // A port that is completing this cycle is not eligible, so a stale request
  // held through its done pulse cannot be granted twice.
  assign req1 = read1 & ~done_q[0];
  assign req2 = (read2 | write2) & ~done_q[1];
  assign req3 = read3 & ~done_q[2];

  mem_sched_prio u_prio (
    .req1  (req1),
    .req2  (req2),
    .req3  (req3),
    .grant (grant)
  );

  assign done1 = done_q[0];
  assign done2 = done_q[1];
  assign done3 = done_q[2];

  assign blocked1 = read1 & ~done_q[0];
  assign blocked2 = (read2 | write2) & ~done_q[1];
  assign blocked3 = read3 & ~done_q[2];

`ifdef MEMSCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Grant in idle, hold the registered access until mem_ready, then pulse done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      port_q    <= PORT_NONE;
      kind_q    <= KIND_READ;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      done_q    <= '0;
`ifdef MEMSCHED_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef MEMSCHED_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (grant != PORT_NONE) begin
            state  <= S_ACCESS;
            port_q <= grant;
`ifdef MEMSCHED_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            case (grant)
              PORT_STACK: begin
                kind_q   <= KIND_READ;
                mem_read <= 1'b1;
                mem_addr <= addr3;
              end
              PORT_DATA: begin
                mem_addr <= addr2;
                if (write2) begin
                  kind_q    <= KIND_WRITE;
                  mem_write <= 1'b1;
                  mem_wdata <= value2;
                end else begin
                  kind_q   <= KIND_READ;
                  mem_read <= 1'b1;
                end
              end
              default: begin
                kind_q   <= KIND_READ;
                mem_read <= 1'b1;
                mem_addr <= addr1;
              end
            endcase
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            state     <= S_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done_q    <= port_onehot(port_q);
            if (kind_q == KIND_READ) begin
              rdata <= mem_rdata;
            end
          end
`ifdef MEMSCHED_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= S_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done_q    <= port_onehot(port_q);
            err_q     <= 1'b1;
            rdata     <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
